// File: rtl/fixed_divider.sv
// Sequential signed fixed-point divider: restoring shift-subtract over DATA_WIDTH+FRAC_BITS
// quotient bits, fixed latency, saturated quotient with divide-by-zero and overflow flags.
module fixed_divider #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] input_a,
  input  logic [DATA_WIDTH-1:0] input_b,
  input  logic                  input_stb,
  output logic                  input_ack,
  output logic [DATA_WIDTH-1:0] output_z,
  output logic                  output_z_stb,
  input  logic                  output_z_ack,
  output logic                  o_div_by_zero,
  output logic                  o_overflow
);

  localparam int W  = DATA_WIDTH;
  localparam int Q  = DATA_WIDTH + FRAC_BITS;
  localparam int CW = $clog2(Q + 1);

  localparam logic [W-1:0]  ZERO_W   = {W{1'b0}};
  localparam logic [W-1:0]  ONE_W    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  MAX_Z    = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  MIN_Z    = {1'b1, {(W-1){1'b0}}};
  localparam logic [Q-1:0]  MAX_MAG  = Q'(MAX_Z);
  localparam logic [Q-1:0]  MIN_MAG  = Q'(MIN_Z);
  localparam logic [CW-1:0] LAST_CNT = CW'(Q - 1);
  localparam logic [CW-1:0] ONE_CNT  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2,
    PUT    = 2'd3
  } state_t;

  state_t         state_r;
  logic [CW-1:0]  count_r;
  logic           sign_r;
  logic           sign_a_r;
  logic           zf_r;
  logic [W-1:0]   divisor_r;
  logic [Q-1:0]   dividend_r;
  logic [W:0]     remainder_r;
  logic [Q-1:0]   quotient_r;

  logic [W-1:0]   abs_a_s;
  logic [W-1:0]   abs_b_s;
  logic [W:0]     rem_shift_s;
  logic           rem_ge_s;
  logic [W:0]     rem_sub_s;
  logic [W-1:0]   neg_m_s;
  logic [W-1:0]   fin_z_s;
  logic           fin_dz_s;
  logic           fin_ovf_s;

  assign input_ack = (state_r == IDLE);

  // Magnitudes are unsigned W-bit values, so |MIN| becomes 2^(W-1) without wrapping
  assign abs_a_s = input_a[W-1] ? (~input_a + ONE_W) : input_a;
  assign abs_b_s = input_b[W-1] ? (~input_b + ONE_W) : input_b;

  assign rem_shift_s = {remainder_r[W-1:0], dividend_r[Q-1]};
  assign rem_ge_s    = (rem_shift_s >= {1'b0, divisor_r});
  assign rem_sub_s   = rem_shift_s - {1'b0, divisor_r};
  assign neg_m_s     = ~quotient_r[W-1:0] + ONE_W;

  // Saturation and sign restoration of the truncated quotient magnitude
  always_comb begin
    fin_z_s   = ZERO_W;
    fin_dz_s  = 1'b0;
    fin_ovf_s = 1'b0;
    if (zf_r) begin
      fin_z_s  = sign_a_r ? MIN_Z : MAX_Z;
      fin_dz_s = 1'b1;
    end else if (!sign_r && (quotient_r > MAX_MAG)) begin
      fin_z_s   = MAX_Z;
      fin_ovf_s = 1'b1;
    end else if (sign_r && (quotient_r > MIN_MAG)) begin
      fin_z_s   = MIN_Z;
      fin_ovf_s = 1'b1;
    end else if (sign_r) begin
      fin_z_s = neg_m_s;
    end else begin
      fin_z_s = quotient_r[W-1:0];
    end
  end

  // Handshake FSM and shift-subtract datapath
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r       <= IDLE;
      count_r       <= {CW{1'b0}};
      sign_r        <= 1'b0;
      sign_a_r      <= 1'b0;
      zf_r          <= 1'b0;
      divisor_r     <= ZERO_W;
      dividend_r    <= {Q{1'b0}};
      remainder_r   <= {(W+1){1'b0}};
      quotient_r    <= {Q{1'b0}};
      output_z      <= ZERO_W;
      output_z_stb  <= 1'b0;
      o_div_by_zero <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (input_stb) begin
            sign_r      <= input_a[W-1] ^ input_b[W-1];
            sign_a_r    <= input_a[W-1];
            zf_r        <= (input_b == ZERO_W);
            divisor_r   <= abs_b_s;
            dividend_r  <= Q'(abs_a_s) << FRAC_BITS;
            remainder_r <= {(W+1){1'b0}};
            quotient_r  <= {Q{1'b0}};
            count_r     <= {CW{1'b0}};
            state_r     <= CALC;
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          // Runs all Q steps regardless of operands so every instance finishes together
          dividend_r  <= {dividend_r[Q-2:0], 1'b0};
          quotient_r  <= {quotient_r[Q-2:0], rem_ge_s};
          remainder_r <= rem_ge_s ? rem_sub_s : rem_shift_s;
          count_r     <= count_r + ONE_CNT;
          if (count_r == LAST_CNT) begin
            state_r <= FINISH;
          end else begin
            state_r <= CALC;
          end
        end
        FINISH: begin
          output_z      <= fin_z_s;
          o_div_by_zero <= fin_dz_s;
          o_overflow    <= fin_ovf_s;
          output_z_stb  <= 1'b1;
          state_r       <= PUT;
        end
        PUT: begin
          if (output_z_ack) begin
            output_z_stb <= 1'b0;
            state_r      <= IDLE;
          end else begin
            state_r <= PUT;
          end
        end
        default: begin
          output_z_stb <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_divider.sv
// Directed testbench for fixed_divider (Q16.16 defaults): results, saturation,
// divide-by-zero, latency, backpressure and asynchronous reset mid-operation.
module tb_fixed_divider;

  logic        clk;
  logic        rst_n;
  logic [31:0] input_a;
  logic [31:0] input_b;
  logic        input_stb;
  logic        input_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;
  logic        o_div_by_zero;
  logic        o_overflow;

  int checks   = 0;
  int failures = 0;

  fixed_divider #(.DATA_WIDTH(32), .FRAC_BITS(16)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .input_a      (input_a),
    .input_b      (input_b),
    .input_stb    (input_stb),
    .input_ack    (input_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack),
    .o_div_by_zero(o_div_by_zero),
    .o_overflow   (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for input_ack, presents operands for one accept edge, returns #1 after it
  task automatic start_div(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!input_ack && n < 200) begin
      @(negedge clk);
      n++;
    end
    input_a   = a;
    input_b   = b;
    input_stb = 1'b1;
    @(posedge clk);
    #1;
    input_stb = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int lat_exp, input logic [31:0] ez,
                             input logic edz, input logic eovf);
    int n;
    n = 0;
    while (!output_z_stb && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({tag, " latency"}, 32'(n), 32'(lat_exp));
    check({tag, " z"}, output_z, ez);
    check({tag, " dz"}, {31'd0, o_div_by_zero}, {31'd0, edz});
    check({tag, " ovf"}, {31'd0, o_overflow}, {31'd0, eovf});
    check({tag, " busy"}, {31'd0, input_ack}, 32'd0);
  endtask

  task automatic take_result(input string tag);
    output_z_ack = 1'b1;
    @(posedge clk);
    #1;
    output_z_ack = 1'b0;
    check({tag, " stb_clr"}, {31'd0, output_z_stb}, 32'd0);
    check({tag, " ack_idle"}, {31'd0, input_ack}, 32'd1);
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ez, input logic edz, input logic eovf);
    start_div(a, b);
    wait_result(tag, 49, ez, edz, eovf);
    take_result(tag);
  endtask

  initial begin
    logic stale;
    rst_n        = 1'b0;
    input_a      = 32'd0;
    input_b      = 32'd0;
    input_stb    = 1'b0;
    output_z_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst z", output_z, 32'd0);
    check("rst stb", {31'd0, output_z_stb}, 32'd0);
    check("rst dz", {31'd0, o_div_by_zero}, 32'd0);
    check("rst ovf", {31'd0, o_overflow}, 32'd0);
    check("rst ack", {31'd0, input_ack}, 32'd1);
    rst_n = 1'b1;

    run_div("3/2",       32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0);
    run_div("-1/4",      32'hFFFF_0000, 32'h0004_0000, 32'hFFFF_C000, 1'b0, 1'b0);
    run_div("1/3",       32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0, 1'b0);
    run_div("-1/3",      32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 1'b0, 1'b0);
    run_div("big/eps",   32'h7FFF_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_div("min/-1",    32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_div("min/1",     32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0);
    run_div("neg/0",     32'hFFFE_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0);
    run_div("pos/0",     32'h0005_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
    run_div("0/0",       32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);

    // Result held under backpressure, then a back-to-back division
    start_div(32'h7FFF_0000, 32'h0000_0001);
    wait_result("hold", 49, 32'h7FFF_FFFF, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold z", output_z, 32'h7FFF_FFFF);
      check("hold stb", {31'd0, output_z_stb}, 32'd1);
      check("hold ovf", {31'd0, o_overflow}, 32'd1);
      check("hold ack", {31'd0, input_ack}, 32'd0);
    end
    take_result("hold");
    run_div("after_hold", 32'h0006_0000, 32'hFFFE_0000, 32'hFFFD_0000, 1'b0, 1'b0);

    // input_stb pulsed during CALC with other operands must be ignored
    start_div(32'h0003_0000, 32'h0002_0000);
    @(negedge clk);
    input_a   = 32'h0001_0000;
    input_b   = 32'h0000_0000;
    input_stb = 1'b1;
    @(negedge clk);
    input_stb = 1'b0;
    wait_result("calc_stb", 48, 32'h0001_8000, 1'b0, 1'b0);
    take_result("calc_stb");

    // Leave a non-zero result and flag, then reset in the middle of CALC
    run_div("pre_rst", 32'hFFFE_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0);
    start_div(32'h0003_0000, 32'h0002_0000);
    repeat (20) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst z", output_z, 32'd0);
    check("mid_rst stb", {31'd0, output_z_stb}, 32'd0);
    check("mid_rst dz", {31'd0, o_div_by_zero}, 32'd0);
    check("mid_rst ovf", {31'd0, o_overflow}, 32'd0);
    check("mid_rst ack", {31'd0, input_ack}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (output_z_stb) stale = 1'b1;
    end
    check("mid_rst stale", {31'd0, stale}, 32'd0);
    run_div("post_rst", 32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fixed_divider.md
Name: fixed_divider

Overview:
- Sequential signed fixed-point divider. It is the responder end of the stb/ack operand/result handshake that the equation-solver row-normalisation stage uses to issue divisions.
- It accepts one operand pair, runs a restoring shift-subtract loop, and returns a saturated quotient with status flags.
- The solver instantiates one per matrix element. Latency is fixed, so all instances in a batch complete on the same cycle.

Parameters:
- DATA_WIDTH, 32: operand and result width, two's complement.
- FRAC_BITS, 16: fractional bits of the Q format for operands and result. Legal range is 0..DATA_WIDTH-1.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- input_a  input  DATA_WIDTH  dividend.
- input_b  input  DATA_WIDTH  divisor.
- input_stb  input  1  operands valid.
- input_ack  output  1  idle; operands can be accepted.
- output_z  output  DATA_WIDTH  quotient.
- output_z_stb  output  1  result valid.
- output_z_ack  input  1  consumer takes result.
- o_div_by_zero  output  1  divisor was zero; valid while output_z_stb=1.
- o_overflow  output  1  quotient saturated; valid while output_z_stb=1.

Behaviour:
- Reset (async, any state) forces state=IDLE, count=0, output_z=0, output_z_stb=0, o_div_by_zero=0, o_overflow=0.
  - input_ack is decoded as (state==IDLE), so it reads 1 during and after reset.
  - An operation in flight is discarded and produces no output.
- Q = DATA_WIDTH+FRAC_BITS quotient bits (48 for defaults).
- States: IDLE, CALC, FINISH, PUT.
- IDLE:
  - input_ack=1.
  - On an edge with input_stb=1, capture sign = a[MSB]^b[MSB], |a|, |b|, and zf = (b==0).
  - Load dividend register = |a| << FRAC_BITS (Q bits wide); clear remainder and count; go to CALC.
  - Operands are sampled only on this edge. Later changes on input_a/input_b are ignored.
- CALC: one restoring step per cycle.
  - Shift the remainder left, bringing in the dividend MSB.
  - If remainder >= |b|, subtract and set the quotient LSB to 1.
  - After exactly Q steps, go to FINISH.
  - The loop runs the full Q cycles even when zf=1 or a=0 (fixed latency).
- FINISH, one cycle. Compute magnitude M of the truncated quotient (toward zero), then:
  - zf=1: output_z = sign_a ? MIN : MAX, o_div_by_zero=1, o_overflow=0. This includes 0/0 -> MAX.
  - Else, positive result and M > 2^(W-1)-1: output_z=MAX, o_overflow=1.
  - Else, negative result and M > 2^(W-1): output_z=MIN, o_overflow=1.
  - Otherwise output_z = sign ? -M : M, with both flags 0.
  - Here MAX=0x7FFF..F and MIN=0x800..0.
  - Set output_z_stb=1 and go to PUT.
- Latency: with the accept edge numbered 0, output_z_stb goes high after edge Q+1 (edge 49 for defaults).
- PUT:
  - output_z, flags and output_z_stb are held stable for any number of cycles while output_z_ack=0.
  - On an edge with output_z_ack=1: clear output_z_stb, go to IDLE. output_z and flags keep their last values.
- Backpressure:
  - input_ack=0 in CALC, FINISH and PUT.
  - input_stb outside IDLE is ignored and not queued.
  - A new operand is accepted no earlier than the cycle after the result handshake.
  - Throughput is one division per Q+3 cycles minimum.
- output_z_ack while output_z_stb=0 is ignored.
- Operands held at input_stb=1 after acceptance are not re-accepted until the FSM returns to IDLE.
- Arithmetic:
  - |MIN| is handled as unsigned 2^(W-1), with no wrap.
  - The remainder register is DATA_WIDTH+1 bits.
  - The count register is wide enough for Q.

Test Plan:
- 3.0/2.0: a=0x00030000, b=0x00020000 -> output_z=0x00018000, flags 0; output_z_stb rises exactly 49 edges after accept.
- Signed truncation:
  - -1.0/4.0: 0xFFFF0000/0x00040000 -> 0xFFFFC000.
  - 1/3: 0x00010000/0x00030000 -> 0x00005555.
  - -1/3: 0xFFFF0000/0x00030000 -> 0xFFFFAAAB.
- Saturation:
  - 0x7FFF0000/0x00000001 -> 0x7FFFFFFF, o_overflow=1.
  - 0x80000000/0xFFFF0000 (i.e. -32768/-1) -> 0x7FFFFFFF, o_overflow=1.
  - 0x80000000/0x00010000 -> 0x80000000, o_overflow=0.
- Divide by zero:
  - 0xFFFE0000/0 -> 0x80000000, o_div_by_zero=1.
  - 0x00050000/0 -> 0x7FFFFFFF, o_div_by_zero=1.
  - 0/0 -> 0x7FFFFFFF, o_div_by_zero=1.
  - All three take the same 49-cycle latency.
- Backpressure:
  - Hold output_z_ack=0 for 10 cycles: output_z and flags stable, output_z_stb=1, input_ack=0 throughout.
  - input_stb pulsed during CALC with new operands: ignored.
  - After ack, input_ack=1 the next cycle and a second division completes correctly.
- Reset mid-operation: assert i_rst_n=0 asynchronously at CALC step 20 -> all outputs 0 and input_ack=1 immediately; no stale output_z_stb; the next division yields the correct result.
